// File: rtl/spi_slave_port_if.sv
// SPI slave port bundle: serial pins plus the byte-wide tx/rx handshake.
//   scl, cs, mosi     serial clock, active-low chip select, data from master
//   miso              serial data to master
//   tx_data/tx_valid  byte offered for transmit; tx_ready = tx buffer empty
//   rx_data/rx_valid  last received byte; rx_valid pulses when it updates
//   busy, tx_underrun, frame_abort  status
// slave modport is used by the port itself; master modport by whatever drives it.
interface spi_slave_port_if;
    logic       scl;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_abort;

    modport slave (
        input  scl, cs, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
    );

    modport master (
        output scl, cs, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI slave endpoint. Synchronises scl/cs/mosi into clk, deserialises mosi
// LSB-first into bytes and serialises a one-entry tx buffer onto miso.
//   clk, rst  system clock, synchronous active-high reset
//   bus       spi_slave_port_if.slave (pins, tx/rx handshake, status pulses)
// TRIG is the scl level the master holds while presenting a bit; the slave
// samples on the transition away from TRIG and updates miso on that same
// transition, so miso is settled long before the master's next drive edge.
module spi_slave_port #(
    parameter bit         TRIG        = 1'b1,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_port_if.slave  bus
);
    localparam logic IDLE_SCL = ~TRIG;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, cs_sync, mosi_sync;
    logic       s_scl, s_cs, s_mosi;
    logic       scl_d, cs_d;
    logic       sample_edge, cs_fall, cs_rise;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       tx_ready;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_abort;

    logic       accept;
    logic       load_pt;
    logic [7:0] next_byte;

    // Synchronisers come out of reset at the idle pin levels so a reset
    // never manufactures a phantom cs or scl edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= {SYNC_STAGES{IDLE_SCL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            scl_d     <= IDLE_SCL;
            cs_d      <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            scl_d     <= s_scl;
            cs_d      <= s_cs;
        end
    end

    assign s_scl  = scl_sync[SYNC_STAGES-1];
    assign s_cs   = cs_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];

    assign sample_edge = (s_scl != TRIG) && (scl_d == TRIG);
    assign cs_fall     = !s_cs && cs_d;
    assign cs_rise     = s_cs && !cs_d;

    // A load point consumes the buffer: at frame start, or when the 8th bit
    // of a byte is sampled and cs is not being released in the same clk.
    always_comb begin
        accept    = bus.tx_valid && tx_ready;
        next_byte = tx_ready ? DEFAULT_TX : tx_buf;
        load_pt   = ((state == IDLE) && cs_fall) ||
                    ((state == SHIFT) && !cs_rise && sample_edge && (bit_cnt == 3'd7));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_ready    <= 1'b1;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;

            // Accept only happens when empty and consume only when full, so
            // a same-clk load+accept leaves the new byte in the buffer.
            if (accept) begin
                tx_buf   <= bus.tx_data;
                tx_ready <= 1'b0;
            end else if (load_pt && !tx_ready) begin
                tx_ready <= 1'b1;
            end

            if (load_pt) begin
                tx_shift    <= next_byte;
                tx_underrun <= tx_ready;
            end

            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (cs_fall) begin
                        miso  <= next_byte[0];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs release beats a coincident sample edge
                    if (cs_rise) begin
                        state       <= IDLE;
                        miso        <= 1'b0;
                        bit_cnt     <= '0;
                        frame_abort <= (bit_cnt != 3'd0);
                    end else if (sample_edge) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {s_mosi, rx_shift};
                            rx_valid <= 1'b1;
                            miso     <= next_byte[0];
                        end else begin
                            rx_shift[bit_cnt] <= s_mosi;
                            miso              <= tx_shift[bit_cnt + 3'd1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso        = miso;
    assign bus.tx_ready    = tx_ready;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.busy        = (state == SHIFT);
    assign bus.tx_underrun = tx_underrun;
    assign bus.frame_abort = frame_abort;
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: dut_a (TRIG=1, DEFAULT_TX=FF) covers the
// framing/buffer/abort/reset cases, dut_b (TRIG=0) a 16-byte duplex stream
// at the tightest legal scl timing.
module tb_spi_slave_port;
    localparam int S    = 2;
    localparam int HALF = S + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_port_if ifa ();
    spi_slave_port_if ifb ();

    spi_slave_port #(.TRIG(1'b1), .SYNC_STAGES(S), .DEFAULT_TX(8'hFF)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    spi_slave_port #(.TRIG(1'b0), .SYNC_STAGES(S), .DEFAULT_TX(8'h00)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    int   total = 0;
    int   bad   = 0;
    bit   sel   = 1'b0;
    logic trig  = 1'b1;

    int rxv_a = 0, und_a = 0, abt_a = 0;
    always @(posedge clk) begin
        if (ifa.rx_valid)    rxv_a <= rxv_a + 1;
        if (ifa.tx_underrun) und_a <= und_a + 1;
        if (ifa.frame_abort) abt_a <= abt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_scl(input logic v);
        if (sel) ifb.scl = v; else ifa.scl = v;
    endtask
    task automatic set_cs(input logic v);
        if (sel) ifb.cs = v; else ifa.cs = v;
    endtask
    task automatic set_mosi(input logic v);
        if (sel) ifb.mosi = v; else ifa.mosi = v;
    endtask
    function automatic logic get_miso();
        return sel ? ifb.miso : ifa.miso;
    endfunction

    task automatic offer(input logic [7:0] d);
        if (sel) begin ifb.tx_data = d; ifb.tx_valid = 1'b1; end
        else     begin ifa.tx_data = d; ifa.tx_valid = 1'b1; end
        tick(1);
        if (sel) ifb.tx_valid = 1'b0; else ifa.tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        set_cs(1'b0);
        tick(HALF);
    endtask
    task automatic cs_high();
        set_cs(1'b1);
        tick(HALF);
    endtask

    // master side: drive bit on the ->TRIG edge, capture miso just before ->~TRIG
    task automatic xfer(input int nbits, input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            set_mosi(mo[i]);
            set_scl(trig);
            tick(HALF);
            mi[i] = get_miso();
            set_scl(~trig);
            tick(HALF);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, 32'(ifa.miso), 32'h0);
        chk({tag, "_rdy"},  32'(ifa.tx_ready), 32'h1);
        chk({tag, "_rxd"},  32'(ifa.rx_data), 32'h0);
        chk({tag, "_rxv"},  32'(ifa.rx_valid), 32'h0);
        chk({tag, "_busy"}, 32'(ifa.busy), 32'h0);
        chk({tag, "_und"},  32'(ifa.tx_underrun), 32'h0);
        chk({tag, "_abt"},  32'(ifa.frame_abort), 32'h0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mo_v [16];
        logic [7:0] tx_v [16];
        int u0, r0, a0;

        ifa.scl = 1'b0; ifa.cs = 1'b1; ifa.mosi = 1'b0; ifa.tx_data = 8'h00; ifa.tx_valid = 1'b0;
        ifb.scl = 1'b1; ifb.cs = 1'b1; ifb.mosi = 1'b0; ifb.tx_data = 8'h00; ifb.tx_valid = 1'b0;
        tick(3);
        chk_reset("rst");
        rst = 1'b0;
        tick(2);

        // T1: preloaded A5 out, 3C in
        offer(8'hA5);
        chk("t1_full", 32'(ifa.tx_ready), 32'h0);
        u0 = und_a; r0 = rxv_a;
        cs_low();
        chk("t1_rdy",  32'(ifa.tx_ready), 32'h1);
        chk("t1_busy", 32'(ifa.busy), 32'h1);
        chk("t1_und",  32'(und_a - u0), 32'h0);
        xfer(8, 8'h3C, mi);
        chk("t1_miso", 32'(mi), 32'hA5);
        chk("t1_rxv",  32'(rxv_a - r0), 32'h1);
        chk("t1_rxd",  32'(ifa.rx_data), 32'h3C);
        cs_high();
        chk("t1_idle", 32'(ifa.busy), 32'h0);
        chk("t1_mz",   32'(ifa.miso), 32'h0);

        // T2: back-to-back bytes with cs held low
        offer(8'h11);
        cs_low();
        offer(8'h22);
        u0 = und_a; r0 = rxv_a;
        xfer(8, 8'h01, mi);
        chk("t2_miso0", 32'(mi), 32'h11);
        chk("t2_rxd0",  32'(ifa.rx_data), 32'h01);
        chk("t2_und",   32'(und_a - u0), 32'h0);
        xfer(8, 8'hFE, mi);
        chk("t2_miso1", 32'(mi), 32'h22);
        chk("t2_rxd1",  32'(ifa.rx_data), 32'hFE);
        chk("t2_rxv",   32'(rxv_a - r0), 32'h2);
        cs_high();

        // T3: empty buffer -> DEFAULT_TX with a single underrun pulse
        u0 = und_a;
        cs_low();
        chk("t3_und", 32'(und_a - u0), 32'h1);
        tick(3);
        chk("t3_und1", 32'(und_a - u0), 32'h1);
        xfer(8, 8'h96, mi);
        chk("t3_miso", 32'(mi), 32'hFF);
        chk("t3_rxd",  32'(ifa.rx_data), 32'h96);
        cs_high();

        // T4: cs released after 5 bits, then a clean byte
        a0 = abt_a; r0 = rxv_a;
        cs_low();
        xfer(5, 8'hE7, mi);
        cs_high();
        chk("t4_abt",  32'(abt_a - a0), 32'h1);
        chk("t4_rxv",  32'(rxv_a - r0), 32'h0);
        chk("t4_rxd",  32'(ifa.rx_data), 32'h96);
        chk("t4_busy", 32'(ifa.busy), 32'h0);
        cs_low();
        xfer(8, 8'h5A, mi);
        cs_high();
        chk("t4_rxd1", 32'(ifa.rx_data), 32'h5A);
        chk("t4_rxv1", 32'(rxv_a - r0), 32'h1);
        chk("t4_abt1", 32'(abt_a - a0), 32'h1);

        // T5: reset mid-byte with a full tx buffer, then a fresh frame
        cs_low();
        offer(8'h77);
        xfer(4, 8'hC3, mi);
        rst = 1'b1;
        tick(1);
        chk_reset("t5");
        set_cs(1'b1);
        set_scl(1'b0);
        tick(3);
        rst = 1'b0;
        tick(1);
        a0 = abt_a;
        cs_low();
        xfer(8, 8'hC3, mi);
        cs_high();
        chk("t5_rxd", 32'(ifa.rx_data), 32'hC3);
        chk("t5_abt", 32'(abt_a - a0), 32'h0);

        // T6: TRIG=0, minimum scl level width, 16 random duplex bytes
        sel = 1'b1;
        trig = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mo_v[k] = 8'($urandom_range(0, 255));
            tx_v[k] = 8'($urandom_range(0, 255));
        end
        offer(tx_v[0]);
        cs_low();
        for (int k = 0; k < 16; k++) begin
            if (k < 15) offer(tx_v[k+1]);
            xfer(8, mo_v[k], mi);
            chk($sformatf("t6_miso%0d", k), 32'(mi), 32'(tx_v[k]));
            chk($sformatf("t6_rxd%0d", k), 32'(ifb.rx_data), 32'(mo_v[k]));
        end
        cs_high();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
